// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply (shift-add) / divide (restoring) unit feeding the HI/LO registers.
// Latency: start sampled at edge N -> done (hi/lo valid) after edge N+33; div0 after edge N+1.
// Backpressure: none; starts are sampled only in IDLE, so starts arriving while busy are dropped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_mult, start_div operation requests (multiply has priority)
//   a, b                  operands rs / rt, held only at the sampling edge
//   busy                  high while an operation iterates
//   done                  one-cycle pulse, hi/lo carry the new result
//   div0                  one-cycle pulse, divide requested with b == 0
//   hi, lo                product upper/lower word, or remainder/quotient
//
// Build option: define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise MULTU/DIVU.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FINISH
  } state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  // Mult: {partial product, remaining multiplier bits}.
  // Div:  {partial remainder, remaining dividend bits / quotient bits}.
  logic [63:0] acc_q;
  logic [31:0] opb_q;      // multiplicand magnitude (mult) or divisor magnitude (div)
  logic        busy_q;
  logic        done_q;
  logic        div0_q;
  logic        div0_pend_q; // div0 is reported one cycle after the request is sampled
  logic [31:0] hi_q;
  logic [31:0] lo_q;

`ifdef MULDIV_SIGNED_EN
  logic        is_div_q;
  logic        neg_lo_q;   // negate low word (or full product for mult)
  logic        neg_hi_q;   // negate remainder (div only)
`endif

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step_d;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_step_d;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

`ifdef MULDIV_SIGNED_EN
  assign a_mag = a[31] ? (32'd0 - a) : a;
  assign b_mag = b[31] ? (32'd0 - b) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set; the carry is kept by shifting it into bit 63.
  assign mul_sum    = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
  assign mul_step_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

  // Restoring step: bring in the next dividend bit and trial-subtract. The
  // partial remainder is always below the divisor, so 33 bits cannot overflow.
  assign div_shift  = acc_q[63:31];
  assign div_diff   = div_shift - {1'b0, opb_q};
  assign div_step_d = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0],  acc_q[30:0], 1'b1};

  always_comb begin
    fix_hi = acc_q[63:32];
    fix_lo = acc_q[31:0];
`ifdef MULDIV_SIGNED_EN
    if (!is_div_q) begin
      if (neg_lo_q) begin
        {fix_hi, fix_lo} = 64'd0 - acc_q;
      end
    end else begin
      if (neg_hi_q) begin
        fix_hi = 32'd0 - acc_q[63:32];
      end
      if (neg_lo_q) begin
        fix_lo = 32'd0 - acc_q[31:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      acc_q       <= 64'd0;
      opb_q       <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div0_q      <= 1'b0;
      div0_pend_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
`ifdef MULDIV_SIGNED_EN
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      div0_q      <= div0_pend_q;
      div0_pend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_mult) begin
            acc_q   <= {32'd0, b_mag};
            opb_q   <= a_mag;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= S_MULT;
`ifdef MULDIV_SIGNED_EN
            is_div_q <= 1'b0;
            neg_lo_q <= a[31] ^ b[31];
            neg_hi_q <= a[31] ^ b[31];
`endif
          end else if (start_div) begin
            if (b != 32'd0) begin
              acc_q   <= {32'd0, a_mag};
              opb_q   <= b_mag;
              cnt_q   <= 6'd0;
              busy_q  <= 1'b1;
              state_q <= S_DIV;
`ifdef MULDIV_SIGNED_EN
              is_div_q <= 1'b1;
              neg_lo_q <= a[31] ^ b[31];
              neg_hi_q <= a[31];
`endif
            end else begin
              div0_pend_q <= 1'b1;
            end
          end
        end
        S_MULT: begin
          acc_q <= mul_step_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= S_FINISH;
          end
        end
        S_DIV: begin
          acc_q <= div_step_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multicycle responder for the MULT and DIV instructions issued by the processor control unit. It latches two 32-bit operands on a start request and iterates one bit per cycle: shift-add for multiply, restoring for divide. It then writes the HI/LO result registers and pulses `done` so the control FSM can leave its wait state. It flags a zero divisor on `div0` so the control unit can enter its divide-by-zero exception state.

## Interface
Parameters:
- none (operand width fixed at 32)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start_mult`  in  1  request multiply of `a`*`b`; sampled only in IDLE
- `start_div`  in  1  request divide `a`/`b`; sampled only in IDLE
- `a`  in  32  operand rs (multiplicand / dividend)
- `b`  in  32  operand rt (multiplier / divisor)
- `busy`  out  1  high while an operation is iterating
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result
- `div0`  out  1  one-cycle pulse; divide requested with `b`==0
- `hi`  out  32  product upper word / remainder
- `lo`  out  32  product lower word / quotient

## Operation
- States: IDLE, MULT, DIV, FINISH. The unit leaves reset in IDLE.
- IDLE:
  - If `start_mult` is high, latch `a`/`b`, clear the 6-bit iteration counter and go to MULT.
  - Otherwise, if `start_div` is high and `b`!=0, latch `a`/`b`, clear the counter and go to DIV.
  - If `start_div` is high and `b`==0, pulse `div0`, stay in IDLE and leave `hi`/`lo` unchanged.
  - If both starts are high together, multiply wins and `start_div` is dropped.
- MULT:
  - Operands are converted to magnitudes and the sign of the result is recorded.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator, then shift right by 1.
  - After 32 iterations (counter reaches 31), go to FINISH.
- DIV:
  - Operands are converted to magnitudes.
  - Each cycle: shift the remainder:dividend pair left by 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit; otherwise restore.
  - After 32 iterations, go to FINISH.
- FINISH: apply the sign fixup, register `hi`/`lo`, pulse `done`, and return to IDLE.
- Signed arithmetic rules:
  - Product is the two's-complement 64-bit result.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This is wrap, not an error.
- Start pulses while `busy` are ignored. The operation in flight is unaffected.
- `hi`/`lo` change only in FINISH or on reset; they hold between operations.

## Timing
- Reset values: `busy`=0, `done`=0, `div0`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset while busy aborts the operation at that edge. No `done` or `div0` is produced.
- Cycle-level sequence, with the start sampled at edge N:
  - `busy`=1 after edge N through edge N+32.
  - After edge N+33: `busy`=0, `done`=1, and `hi`/`lo` are valid.
  - After edge N+34: `done`=0. A new start may be sampled at edge N+34.
- Divide-by-zero latency: start at edge N gives `div0`=1 after edge N+1 and 0 after edge N+2. `busy` never rises.
- `done` and `div0` are never high in the same cycle.
- The control FSM waits on `done`/`div0`. It must hold operands only at the sampling edge.

## Configuration
- `MULDIV_SIGNED_EN` defined: signed MULT/DIV semantics with magnitude conversion and sign fixup, as above.
- `MULDIV_SIGNED_EN` undefined:
  - Operands are treated as unsigned (MULTU/DIVU semantics).
  - The sign-fixup logic is removed.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0, `hi`=0x80000000.
  - Latency is unchanged.

## Test plan
- Signed mult, `a`=7, `b`=0xFFFFFFFD (-3) -> `done` after edge N+33 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- Signed div, `a`=0xFFFFFFF9 (-7), `b`=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; then div `a`=0x80000000, `b`=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- `start_div` with `b`=0 and prior `hi`/`lo`=0x1234/0x5678 -> `div0` for one cycle after edge N+1; `busy`=0 throughout; `hi`/`lo` unchanged.
- `start_mult` and `start_div` together with `a`=3, `b`=5, then `start_div` pulsed mid-operation -> only the multiply runs; `lo`=15, `hi`=0, single `done` pulse.
- `reset` asserted 10 cycles into a divide -> next cycle `busy`=0, `hi`=`lo`=0, no `done`; a fresh mult 6*7 then yields `lo`=42.
- Build without `MULDIV_SIGNED_EN`, mult `a`=0xFFFFFFFF, `b`=2 -> `hi`=1, `lo`=0xFFFFFFFE.
